// File: rtl/vector_lane_sequencer.sv
// Steps one vector operation across LANES elements: read lane i, write lane i next cycle.
// Optional macro SCALAR_BROADCAST_EN allows scalar (code < 16) source operands.
module vector_lane_sequencer #(
  parameter int LANES  = 8,
  parameter int LANE_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [4:0]        RdCode,
  input  logic [4:0]        RaCode,
  input  logic [4:0]        RbCode,
  input  logic              stall,
  output logic              ready,
  output logic [3:0]        RdVector,
  output logic [3:0]        RaVector,
  output logic [3:0]        RbVector,
  output logic              RaIsVector,
  output logic              RbIsVector,
  output logic              ReadEn,
  output logic [LANE_W-1:0] ReadLane,
  output logic              WriteEn,
  output logic [LANE_W-1:0] WriteLane,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  state_t            state;
  logic [LANE_W-1:0] lane;
  logic              legal;
  logic              read_acc;
  logic              last_lane;

  always_comb begin
`ifdef SCALAR_BROADCAST_EN
    legal = RdCode[4];
`else
    legal = RdCode[4] & RaCode[4] & RbCode[4];
`endif
    read_acc  = (state == RUN) && !stall;
    last_lane = (lane == LAST_LANE);
  end

  // ready drops combinationally with reset so nothing is accepted while reset is held
  assign ready    = (state == IDLE) && !reset;
  assign ReadEn   = read_acc;
  assign ReadLane = lane;

`ifdef SCALAR_BROADCAST_EN
  logic ra_isv;
  logic rb_isv;
  assign RaIsVector = ra_isv;
  assign RbIsVector = rb_isv;

  always_ff @(posedge clk) begin
    if (reset) begin
      ra_isv <= 1'b0;
      rb_isv <= 1'b0;
    end else if (state == IDLE && start && legal) begin
      ra_isv <= RaCode[4];
      rb_isv <= RbCode[4];
    end
  end
`else
  assign RaIsVector = 1'b1;
  assign RbIsVector = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lane      <= '0;
      RdVector  <= '0;
      RaVector  <= '0;
      RbVector  <= '0;
      WriteEn   <= 1'b0;
      WriteLane <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      // every accepted read retires as a write one cycle later, independent of stall
      WriteEn   <= read_acc;
      WriteLane <= lane;
      done      <= read_acc && last_lane;
      error     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (legal) begin
              RdVector <= RdCode[3:0];
              RaVector <= RaCode[4] ? RaCode[3:0] : 4'd0;
              RbVector <= RbCode[4] ? RbCode[3:0] : 4'd0;
              lane     <= '0;
              state    <= RUN;
            end else begin
              error <= 1'b1;
            end
          end
        end
        RUN: begin
          if (read_acc) begin
            if (last_lane) state <= DRAIN;
            else           lane  <= lane + 1'b1;
          end
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Bench for vector_lane_sequencer: directed table, corner sequences, random run vs reference model.
// Honours SCALAR_BROADCAST_EN the same way as the design.
module tb_vector_lane_sequencer;

  localparam int LANES  = 8;
  localparam int LANE_W = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [4:0]        RdCode, RaCode, RbCode;
  logic              stall;
  logic              ready;
  logic [3:0]        RdVector, RaVector, RbVector;
  logic              RaIsVector, RbIsVector;
  logic              ReadEn;
  logic [LANE_W-1:0] ReadLane;
  logic              WriteEn;
  logic [LANE_W-1:0] WriteLane;
  logic              done;
  logic              error;

  vector_lane_sequencer #(.LANES(LANES), .LANE_W(LANE_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .RdCode(RdCode), .RaCode(RaCode), .RbCode(RbCode), .stall(stall),
    .ready(ready), .RdVector(RdVector), .RaVector(RaVector), .RbVector(RbVector),
    .RaIsVector(RaIsVector), .RbIsVector(RbIsVector),
    .ReadEn(ReadEn), .ReadLane(ReadLane), .WriteEn(WriteEn), .WriteLane(WriteLane),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: an operation is "lanes still to read"; writes trail reads by one cycle.
  bit m_reading = 0;
  int m_lane    = 0;
  int m_wr      = -1;
  bit m_done    = 0;
  bit m_err     = 0;
  int m_rd = 0, m_ra = 0, m_rb = 0;
  bit m_ra_isv = 0, m_rb_isv = 0;

  bit s_ready, s_ren, s_wen, s_done, s_err, s_raisv;
  int s_rlane, s_wlane, s_rav;

  typedef struct {
    bit       start;
    logic [4:0] rd, ra, rb;
    bit       ready, ren;
    int       rlane;
    bit       wen;
    int       wlane;
    bit       done, err;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit illegal(input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb);
`ifdef SCALAR_BROADCAST_EN
    return !rd[4];
`else
    return !rd[4] || !ra[4] || !rb[4];
`endif
  endfunction

  function automatic bit exp_ready();
    return !reset && !m_reading && !m_done;
  endfunction

  task automatic check_model();
    chk("ready", int'(ready), int'(exp_ready()));
    chk("ReadEn", int'(ReadEn), int'(m_reading && !stall));
    if (m_reading && !stall) chk("ReadLane", int'(ReadLane), m_lane);
    chk("WriteEn", int'(WriteEn), int'(m_wr >= 0));
    if (m_wr >= 0) chk("WriteLane", int'(WriteLane), m_wr);
    chk("done", int'(done), int'(m_done));
    chk("error", int'(error), int'(m_err));
    chk("RdVector", int'(RdVector), m_rd);
    chk("RaVector", int'(RaVector), m_ra);
    chk("RbVector", int'(RbVector), m_rb);
`ifdef SCALAR_BROADCAST_EN
    chk("RaIsVector", int'(RaIsVector), int'(m_ra_isv));
    chk("RbIsVector", int'(RbIsVector), int'(m_rb_isv));
`else
    chk("RaIsVector", int'(RaIsVector), 1);
    chk("RbIsVector", int'(RbIsVector), 1);
`endif
  endtask

  task automatic model_update();
    bit acc;
    bit rdy;
    rdy = exp_ready();
    if (reset) begin
      m_reading = 0; m_lane = 0; m_wr = -1; m_done = 0; m_err = 0;
      m_rd = 0; m_ra = 0; m_rb = 0; m_ra_isv = 0; m_rb_isv = 0;
    end else begin
      acc    = m_reading && !stall;
      m_wr   = acc ? m_lane : -1;
      m_done = acc && (m_lane == LANES - 1);
      m_err  = start && rdy && illegal(RdCode, RaCode, RbCode);
      if (acc) begin
        if (m_lane == LANES - 1) m_reading = 0;
        else m_lane++;
      end
      if (start && rdy && !illegal(RdCode, RaCode, RbCode)) begin
        m_reading = 1;
        m_lane    = 0;
        m_rd      = int'(RdCode[3:0]);
        m_ra      = RaCode[4] ? int'(RaCode[3:0]) : 0;
        m_rb      = RbCode[4] ? int'(RbCode[3:0]) : 0;
        m_ra_isv  = RaCode[4];
        m_rb_isv  = RbCode[4];
      end
    end
  endtask

  task automatic tick(input bit s, input logic [4:0] rd, input logic [4:0] ra,
                      input logic [4:0] rb, input bit st, input bit rs);
    start = s; RdCode = rd; RaCode = ra; RbCode = rb; stall = st; reset = rs;
    @(negedge clk);
    check_model();
    s_ready = ready;  s_ren = ReadEn;  s_rlane = int'(ReadLane);
    s_wen = WriteEn;  s_wlane = int'(WriteLane);
    s_done = done;    s_err = error;   s_raisv = RaIsVector;  s_rav = int'(RaVector);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 30; i++) begin
      tick(0, 5'h10, 5'h10, 5'h10, 0, 0);
      if (s_ready) begin ok = 1; break; end
    end
    chk("wait_idle", int'(ok), 1);
  endtask

  initial begin
    int done_at, reads, first_lane, dones, accepts;

    for (int k = 0; k <= 10; k++) begin
      tbl[k].start = (k == 0);
      tbl[k].rd = 5'b10010; tbl[k].ra = 5'b10000; tbl[k].rb = 5'b11111;
      tbl[k].ready = (k == 0) || (k == 10);
      tbl[k].ren   = (k >= 1) && (k <= 8);
      tbl[k].rlane = k - 1;
      tbl[k].wen   = (k >= 2) && (k <= 9);
      tbl[k].wlane = k - 2;
      tbl[k].done  = (k == 9);
      tbl[k].err   = 0;
    end
    tbl[11] = '{start: 1, rd: 5'b01111, ra: 5'b10000, rb: 5'b10000, ready: 1, ren: 0,
                rlane: 0, wen: 0, wlane: 0, done: 0, err: 0};
    tbl[12] = '{start: 0, rd: 5'b01111, ra: 5'b10000, rb: 5'b10000, ready: 1, ren: 0,
                rlane: 0, wen: 0, wlane: 0, done: 0, err: 1};

    reset = 1; start = 0; stall = 0; RdCode = '0; RaCode = '0; RbCode = '0;
    repeat (2) @(posedge clk);
    #1;
    tick(0, 5'h10, 5'h10, 5'h10, 0, 1);

    for (int r = 0; r < 13; r++) begin
      tick(tbl[r].start, tbl[r].rd, tbl[r].ra, tbl[r].rb, 0, 0);
      chk($sformatf("tbl%0d_ready", r), int'(s_ready), int'(tbl[r].ready));
      chk($sformatf("tbl%0d_ren", r), int'(s_ren), int'(tbl[r].ren));
      if (tbl[r].ren) chk($sformatf("tbl%0d_rlane", r), s_rlane, tbl[r].rlane);
      chk($sformatf("tbl%0d_wen", r), int'(s_wen), int'(tbl[r].wen));
      if (tbl[r].wen) chk($sformatf("tbl%0d_wlane", r), s_wlane, tbl[r].wlane);
      chk($sformatf("tbl%0d_done", r), int'(s_done), int'(tbl[r].done));
      chk($sformatf("tbl%0d_err", r), int'(s_err), int'(tbl[r].err));
    end
    chk("held_RdVector", int'(RdVector), 2);
    chk("held_RaVector", int'(RaVector), 0);
    chk("held_RbVector", int'(RbVector), 15);

    // stall for two cycles while lane 3 is presented
    tick(1, 5'b10010, 5'b10000, 5'b11111, 0, 0);
    done_at = -1;
    for (int k = 1; k <= 20; k++) begin
      tick(0, 5'h10, 5'h10, 5'h10, (k == 4) || (k == 5), 0);
      if (k == 4) begin
        chk("stall_ren", int'(s_ren), 0);
        chk("stall_wen", int'(s_wen), 1);
        chk("stall_wlane", s_wlane, 2);
      end
      if (k == 6) chk("stall_reread", s_rlane, 3);
      if (s_done && done_at < 0) done_at = k;
    end
    chk("stall_done_cycle", done_at, 11);
    wait_idle();

    // scalar source A
    tick(1, 5'b10001, 5'b00011, 5'b10000, 0, 0);
    tick(0, 5'h10, 5'h10, 5'h10, 0, 0);
`ifdef SCALAR_BROADCAST_EN
    chk("scalar_err", int'(s_err), 0);
    chk("scalar_ren", int'(s_ren), 1);
    chk("scalar_raisv", int'(s_raisv), 0);
    chk("scalar_rav", s_rav, 0);
`else
    chk("scalar_err", int'(s_err), 1);
    chk("scalar_ren", int'(s_ren), 0);
    chk("scalar_ready", int'(s_ready), 1);
`endif
    wait_idle();

    // reset while lane 4 is being read, then a clean full operation
    tick(1, 5'b10101, 5'b10110, 5'b10111, 0, 0);
    for (int k = 1; k <= 5; k++) tick(0, 5'h10, 5'h10, 5'h10, 0, k == 5);
    chk("rst_lane", s_rlane, 4);
    tick(0, 5'h10, 5'h10, 5'h10, 0, 0);
    chk("rst_ren", int'(s_ren), 0);
    chk("rst_wen", int'(s_wen), 0);
    chk("rst_done", int'(s_done), 0);
    chk("rst_ready", int'(s_ready), 1);
    tick(1, 5'b11000, 5'b11001, 5'b11010, 0, 0);
    reads = 0; first_lane = -1;
    for (int k = 0; k < 12; k++) begin
      tick(0, 5'h10, 5'h10, 5'h10, 0, 0);
      if (s_ren) begin
        if (first_lane < 0) first_lane = s_rlane;
        reads++;
      end
    end
    chk("rst_rerun_first_lane", first_lane, 0);
    chk("rst_rerun_reads", reads, LANES);

    // start held high: one operation per LANES+2 cycles
    dones = 0; accepts = 0;
    for (int k = 0; k < 4 * (LANES + 2); k++) begin
      tick(1, 5'b10011, 5'b10100, 5'b10101, 0, 0);
      if (s_done) dones++;
      if (s_ready) accepts++;
    end
    chk("cont_dones", dones, 4);
    chk("cont_accepts", accepts, 4);
    wait_idle();

    for (int k = 0; k < 3000; k++) begin
      tick(($urandom % 3) == 0,
           {($urandom % 5) != 0, 4'($urandom)},
           {($urandom % 4) != 0, 4'($urandom)},
           {($urandom % 4) != 0, 4'($urandom)},
           ($urandom % 3) == 0,
           ($urandom % 250) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vector_lane_sequencer.md
Name: vector_lane_sequencer

Overview:
- Sequences one vector operation across all lanes of the vector register file.
- Accepts a 5-bit register-code triple (Rd, Ra, Rb) and decodes codes 16..31 to vector registers 0..15.
- Steps a lane counter one element per cycle, driving read enables/addresses and, one cycle later, write enables to the register file.
- Sits between instruction decode and the vector register file. A stall input lets a competing port (e.g. the VGA read path) hold off reads.

Parameters:
- LANES, 8, elements per vector register (power of two, >=2).
- LANE_W, 3, lane index width = log2(LANES).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin an operation; accepted only when ready=1.
- RdCode  input  5  destination register code.
- RaCode  input  5  source A register code.
- RbCode  input  5  source B register code.
- stall  input  1  register-file read port unavailable this cycle.
- ready  output  1  sequencer idle, can accept start.
- RdVector  output  4  latched destination vector register number.
- RaVector  output  4  latched source A vector register number.
- RbVector  output  4  latched source B vector register number.
- RaIsVector  output  1  source A is a vector register (code>=16).
- RbIsVector  output  1  source B is a vector register (code>=16).
- ReadEn  output  1  read lane ReadLane from Ra/Rb this cycle.
- ReadLane  output  LANE_W  lane index being read.
- WriteEn  output  1  write lane WriteLane of Rd this cycle.
- WriteLane  output  LANE_W  lane index being written.
- done  output  1  one-cycle pulse when the final lane is written.
- error  output  1  one-cycle pulse when a start is rejected for an illegal code.

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - Registered outputs go to 0: state=IDLE, vector fields, IsVector flags, lanes, ReadEn, WriteEn, done, error.
  - ready=0 while reset is high; ready=1 from the first cycle after reset deasserts.
- Code decode:
  - Code c with c[4]=1 maps to vector number c[3:0], IsVector=1.
  - Code with c[4]=0 gives IsVector=0 and vector field 0.
- States:
  - IDLE: ready=1. On start=1:
    - If RdCode[4]=0, or a source is illegal (see Optional Feature): pulse error next cycle, stay IDLE, latch nothing.
    - Otherwise: latch decoded codes, lane counter=0, go to RUN.
  - RUN: ready=0.
    - ReadEn=!stall, ReadLane=lane counter.
    - Each cycle with ReadEn=1 (accepted read), the lane counter increments.
    - The accepted read at lane LANES-1 moves the state to DRAIN.
  - DRAIN: one cycle. WriteEn=1 with WriteLane=LANES-1, done=1, then go to IDLE.
- Write pipeline:
  - Each accepted read at lane i produces WriteEn=1, WriteLane=i in the following cycle.
  - This write happens regardless of stall; stall blocks reads only.
  - WriteEn=0 in any cycle not preceded by an accepted read.
- Latency: with no stall, start accepted at cycle T gives reads at T+1..T+LANES, writes at T+2..T+LANES+1, done at T+LANES+1. Each stalled cycle adds one cycle.
- start is ignored while ready=0; no queuing.
- The lane counter never wraps inside an operation. It resets to 0 on each accepted start.
- Next start:
  - ready returns to 1 in the cycle after done.
  - A start in the done cycle is ignored.
- Reset mid-operation: abort immediately. No further ReadEn/WriteEn, no done pulse, return to IDLE.
- Latched vector fields hold their value after done until the next accepted start.

Optional Feature:
- Macro: SCALAR_BROADCAST_EN.
- Defined:
  - A source code <16 is legal; its IsVector=0 and vector field=0.
  - The datapath broadcasts the scalar register to every lane.
- Undefined:
  - Any source code <16 is illegal; start is rejected with an error pulse.
  - RaIsVector and RbIsVector are tied to 1.
- In both builds, a destination code <16 is always illegal.

Test Plan:
- Reset then start with Rd=5'b10010, Ra=5'b10000, Rb=5'b11111, no stall -> RdVector=2, RaVector=0, RbVector=15; ReadLane 0..7 on 8 consecutive cycles; WriteLane 0..7 one cycle behind; done 9 cycles after start; ready=1 the cycle after.
- Same op with stall high for 2 cycles at lane 3 -> ReadEn low for 2 cycles, lane 3 re-read after stall; write of lane 2 still occurs in the first stall cycle; done at cycle 11.
- start with Rd=5'b01111 -> error pulse 1 cycle, ready stays 1, no ReadEn/WriteEn.
- Ra=5'b00011, Rd=5'b10001:
  - With SCALAR_BROADCAST_EN: runs, RaIsVector=0, RaVector=0.
  - Without: error pulse, no run.
- reset asserted at lane 4 -> next cycle ReadEn=WriteEn=done=0 and state IDLE; then a new start runs a full 8 lanes from lane 0.
- start held high continuously -> exactly one operation per LANES+2 cycles; starts during RUN and DRAIN are ignored.
